// File: rtl/mux_scan_pkg.sv
// rtl/mux_scan_pkg.sv - shared types and default constants for the mux scan sampler
package mux_scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam int NUM_CH_DEF     = 8;
    localparam int SETTLE_CYC_DEF = 1;

endpackage

// File: rtl/mux_scan_timer.sv
// rtl/mux_scan_timer.sv - loadable down-counter timing the per-channel settle wait
module mux_scan_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Load takes priority; otherwise count down and park at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = value;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/mux_scan_sampler.sv
// rtl/mux_scan_sampler.sv - scans an 8:1 mux, assembles a word, presents it on valid/ready (option: SCAN_PARITY_EN)
module mux_scan_sampler
    import mux_scan_pkg::*;
#(
    parameter int NUM_CH     = NUM_CH_DEF,
    parameter int SEL_W      = $clog2(NUM_CH),
    parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cont,
    output logic [SEL_W-1:0]  mux_sel,
    input  logic              mux_out,
    output logic [NUM_CH-1:0] word_data,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              busy
`ifdef SCAN_PARITY_EN
    ,
    output logic              word_parity
`endif
);

    // The sample cycle itself is one of the SETTLE_CYC+1 cycles per channel,
    // so the timer holds the number of extra SETTLE cycles still to spend.
    localparam int         SETTLE_LOAD_I = (SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0;
    localparam logic [3:0] SETTLE_LOAD   = 4'(SETTLE_LOAD_I);
    localparam state_t     CH_ENTRY      = (SETTLE_CYC == 0) ? SAMPLE : SETTLE;
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

    state_t              state_q,  state_d;
    logic [SEL_W-1:0]    ch_q,     ch_d;
    logic [NUM_CH-1:0]   shadow_q, shadow_d;
    logic [NUM_CH-1:0]   word_q,   word_d;
    logic                valid_q,  valid_d;
    logic                tmr_load;
    logic                tmr_zero;

    mux_scan_timer #(.CNT_W(4)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (tmr_load),
        .value (SETTLE_LOAD),
        .zero  (tmr_zero)
    );

    // Next-state logic: walk channels, fill the shadow, publish on the last sample.
    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        shadow_d = shadow_q;
        word_d   = word_q;
        valid_d  = valid_q;
        tmr_load = 1'b0;
        case (state_q)
            IDLE: begin
                ch_d = '0;
                if (start) begin
                    state_d  = CH_ENTRY;
                    tmr_load = 1'b1;
                end
            end
            SETTLE: begin
                if (tmr_zero) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                shadow_d[ch_q] = mux_out;
                if (ch_q == LAST_CH) begin
                    state_d = HOLD;
                    word_d  = shadow_d;
                    valid_d = 1'b1;
                end else begin
                    ch_d     = ch_q + SEL_W'(1);
                    state_d  = CH_ENTRY;
                    tmr_load = 1'b1;
                end
            end
            HOLD: begin
                if (word_ready) begin
                    valid_d = 1'b0;
                    ch_d    = '0;
                    if (cont) begin
                        state_d  = CH_ENTRY;
                        tmr_load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                ch_d    = '0;
            end
        endcase
    end

    // FSM, channel, shadow and output registers; reset discards any partial scan.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ch_q     <= '0;
            shadow_q <= '0;
            word_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            shadow_q <= shadow_d;
            word_q   <= word_d;
            valid_q  <= valid_d;
        end
    end

`ifdef SCAN_PARITY_EN
    logic parity_q;
    logic parity_d;

    // Parity tracks word_data, so it is computed from the word's next value.
    always_comb begin
        parity_d = ^word_d;
    end

    // Parity register, updated alongside word_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign word_parity = parity_q;
`endif

    assign mux_sel    = ch_q;
    assign word_data  = word_q;
    assign word_valid = valid_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mux_scan_sampler.sv
// tb/tb_mux_scan_sampler.sv - directed scoreboard bench for mux_scan_sampler
module tb_mux_scan_sampler;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       start0, cont0, ready0, mux_out0, valid0, busy0;
    logic [2:0] sel0;
    logic [7:0] data0, in0;

    logic       start1, cont1, ready1, mux_out1, valid1, busy1;
    logic [2:0] sel1;
    logic [7:0] data1, in1;

`ifdef SCAN_PARITY_EN
    logic       par0, par1;
`endif

    int         tests = 0;
    int         fails = 0;
    int         lat;
    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];

    always #5 clk = ~clk;

    assign mux_out0 = in0[sel0];
    assign mux_out1 = in1[sel1];

    mux_scan_sampler u_dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start0),
        .cont       (cont0),
        .mux_sel    (sel0),
        .mux_out    (mux_out0),
        .word_data  (data0),
        .word_valid (valid0),
        .word_ready (ready0),
        .busy       (busy0)
`ifdef SCAN_PARITY_EN
        ,
        .word_parity(par0)
`endif
    );

    mux_scan_sampler #(.SETTLE_CYC(0)) u_dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start1),
        .cont       (cont1),
        .mux_sel    (sel1),
        .mux_out    (mux_out1),
        .word_data  (data1),
        .word_valid (valid1),
        .word_ready (ready1),
        .busy       (busy1)
`ifdef SCAN_PARITY_EN
        ,
        .word_parity(par1)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Called at the negedge after the start-accepting edge; returns edges until valid.
    task automatic wait_valid0(input int budget, input bit chk_sel, output int l);
        l = 0;
        if (chk_sel) check("sel_step", {29'd0, sel0}, 0);
        while (!valid0 && l < budget) begin
            tick();
            l++;
            if (chk_sel && !valid0) check("sel_step", {29'd0, sel0}, l / 2);
        end
        check("valid0_rise", {31'd0, valid0}, 1);
    endtask

    // Pulses start1 mid-scan to show it is ignored while busy.
    task automatic wait_valid1(input int budget, output int l);
        l = 0;
        while (!valid1 && l < budget) begin
            tick();
            l++;
            start1 = (l == 3);
        end
        start1 = 1'b0;
        check("valid1_rise", {31'd0, valid1}, 1);
    endtask

    task automatic pop_check0(input string tag);
        logic [7:0] e;
        check({tag, "_sb_nonempty"}, {31'd0, exp_q0.size() != 0}, 1);
        if (exp_q0.size() != 0) begin
            e = exp_q0.pop_front();
            check(tag, {24'd0, data0}, {24'd0, e});
        end
    endtask

    task automatic pop_check1(input string tag);
        logic [7:0] e;
        check({tag, "_sb_nonempty"}, {31'd0, exp_q1.size() != 0}, 1);
        if (exp_q1.size() != 0) begin
            e = exp_q1.pop_front();
            check(tag, {24'd0, data1}, {24'd0, e});
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        start0 = 1'b0; cont0 = 1'b0; ready0 = 1'b0; in0 = 8'h00;
        start1 = 1'b0; cont1 = 1'b0; ready1 = 1'b0; in1 = 8'h00;
        tick(); tick();
        check("rst_sel",   {29'd0, sel0},   0);
        check("rst_data",  {24'd0, data0},  0);
        check("rst_valid", {31'd0, valid0}, 0);
        check("rst_busy",  {31'd0, busy0},  0);
        rst_n = 1'b1;
        tick();

        // Reset while settling channel 3
        in0    = 8'h5A;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (sel0 == 3'd3) break;
            tick();
        end
        check("pre_rst_sel",  {29'd0, sel0},  3);
        check("pre_rst_busy", {31'd0, busy0}, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_sel",   {29'd0, sel0},   0);
        check("midrst_busy",  {31'd0, busy0},  0);
        tick();
        check("midrst_data",  {24'd0, data0},  0);
        check("midrst_valid", {31'd0, valid0}, 0);
        check("midrst_sel2",  {29'd0, sel0},   0);
        check("midrst_busy2", {31'd0, busy0},  0);
        rst_n = 1'b1;
        tick();
        check("post_rst_busy", {31'd0, busy0}, 0);

        // Single scan
        in0    = 8'hA5;
        ready0 = 1'b1;
        exp_q0.push_back(8'hA5);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        wait_valid0(40, 1'b1, lat);
        check("single_lat", lat, 16);
        pop_check0("single_word");
        tick();
        check("single_valid_drop", {31'd0, valid0}, 0);
        check("single_busy_drop",  {31'd0, busy0},  0);

        // Back-pressure
        ready0 = 1'b0;
        in0    = 8'hA5;
        exp_q0.push_back(8'hA5);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        wait_valid0(40, 1'b0, lat);
        check("bp_lat", lat, 16);
        in0 = 8'h3C;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("bp_valid_hold", {31'd0, valid0}, 1);
            check("bp_data_hold",  {24'd0, data0},  {24'd0, exp_q0[0]});
        end
        ready0 = 1'b1;
        pop_check0("bp_word");
        tick();
        check("bp_valid_drop", {31'd0, valid0}, 0);

        // Continuous scan
        cont0  = 1'b1;
        in0    = 8'hFF;
        exp_q0.push_back(8'hFF);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        wait_valid0(40, 1'b0, lat);
        check("cont1_lat", lat, 16);
        pop_check0("cont_word1");
        in0 = 8'h00;
        exp_q0.push_back(8'h00);
        tick();
        cont0 = 1'b0;
        check("cont_busy_after_hs", {31'd0, busy0},  1);
        check("cont_valid_drop",    {31'd0, valid0}, 0);
        wait_valid0(40, 1'b1, lat);
        check("cont2_lat", lat, 16);
        pop_check0("cont_word2");
        tick();
        check("cont_end_busy", {31'd0, busy0}, 0);

        // Zero settle time, start ignored while busy
        in1 = 8'h81;
        exp_q1.push_back(8'h81);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        wait_valid1(40, lat);
        check("zs_lat", lat, 8);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("zs_hold_valid", {31'd0, valid1}, 1);
        ready1 = 1'b1;
        pop_check1("zs_word");
        tick();
        check("zs_busy_drop", {31'd0, busy1}, 0);
        tick();
        check("zs_no_queue", {31'd0, busy1}, 0);

`ifdef SCAN_PARITY_EN
        // Parity
        ready0 = 1'b1;
        in0    = 8'h07;
        exp_q0.push_back(8'h07);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        wait_valid0(40, 1'b0, lat);
        check("par_07", {31'd0, par0}, 1);
        pop_check0("par_word07");
        tick();
        in0 = 8'h03;
        exp_q0.push_back(8'h03);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        wait_valid0(40, 1'b0, lat);
        check("par_03", {31'd0, par0}, 0);
        pop_check0("par_word03");
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
